// File: rtl/mod_reduce.sv
// mod_reduce: final conditional subtraction after the multi-precision adder.
// Returns X - M when X >= M, else X, using one CHUNK-bit subtractor slice
// stepped over NCHUNK cycles. The final carry out of the chained slices is
// the only X >= M decision; there is no separate comparator.
module mod_reduce #(
  parameter int unsigned WIDTH = 1027,
  parameter int unsigned CHUNK = 257
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH:0]   in_x,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             reduced,
  output logic             busy,
  output logic             done
);

  localparam int unsigned XW     = WIDTH + 1;
  localparam int unsigned NCHUNK = XW / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_SEL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Datapath registers and their next values
  logic [XW-1:0]    r_x;
  logic [XW-1:0]    w_x_nxt;
  logic [WIDTH-1:0] r_keep;
  logic [WIDTH-1:0] w_keep_nxt;
  logic [XW-1:0]    r_m;
  logic [XW-1:0]    w_m_nxt;
  logic             r_carry;
  logic             w_carry_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;

  // Registered outputs and their next values
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_nxt;
  logic             r_reduced;
  logic             w_reduced_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;

  // One slice of X + ~M + carry; bit CHUNK is the carry into the next slice
  logic [CHUNK:0]   w_diff;

  // Subtractor slice on the low chunk of the rotating operand registers
  always_comb begin
    w_diff = {1'b0, r_x[CHUNK-1:0]} + {1'b0, ~r_m[CHUNK-1:0]} + (CHUNK+1)'(r_carry);
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath/output next-value logic
  always_comb begin
    w_state_nxt   = r_state;
    w_x_nxt       = r_x;
    w_keep_nxt    = r_keep;
    w_m_nxt       = r_m;
    w_carry_nxt   = r_carry;
    w_cnt_nxt     = r_cnt;
    w_result_nxt  = r_result;
    w_reduced_nxt = r_reduced;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // The done-pulse cycle still belongs to the previous operation,
        // so a start seen while done is high is not accepted.
        if (start && !r_done) begin
          w_x_nxt     = in_x;
          w_keep_nxt  = in_x[WIDTH-1:0];
          w_m_nxt     = {1'b0, in_m};
          w_carry_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_SUB;
        end
      end

      S_SUB: begin
        // Difference chunks enter at the top; after NCHUNK steps r_x holds X - M
        w_x_nxt     = {w_diff[CHUNK-1:0], r_x[XW-1:CHUNK]};
        w_m_nxt     = r_m >> CHUNK;
        w_carry_nxt = w_diff[CHUNK];
        w_cnt_nxt   = r_cnt + CW'(1);
        if (r_cnt == CW'(NCHUNK - 1)) begin
          w_state_nxt = S_SEL;
        end
      end

      S_SEL: begin
        // Final carry set means no borrow, i.e. X >= M
        if (r_carry) begin
          w_result_nxt  = r_x[WIDTH-1:0];
          w_reduced_nxt = 1'b1;
        end else begin
          w_result_nxt  = r_keep;
          w_reduced_nxt = 1'b0;
        end
        w_state_nxt = S_DONE;
      end

      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x       <= '0;
      r_keep    <= '0;
      r_m       <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_reduced <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_x       <= w_x_nxt;
      r_keep    <= w_keep_nxt;
      r_m       <= w_m_nxt;
      r_carry   <= w_carry_nxt;
      r_cnt     <= w_cnt_nxt;
      r_result  <= w_result_nxt;
      r_reduced <= w_reduced_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign result  = r_result;
  assign reduced = r_reduced;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
